fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction queue between the fetch stage and decode. Captures each fetched {PC, instruction} pair through a valid/ready handshake and presents them in order to decode. When decode stalls, fetch keeps running until the queue fills. A single-cycle flush discards all queued entries when the PC is redirected by a taken branch, jr or j, so that no wrong-path instruction reaches decode.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- WORD_W, 32, width of PC and instruction words

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch presents a valid {in_pc, in_instr}
- in_ready  out  1  queue accepts the entry this cycle
- in_pc  in  WORD_W  PC of the fetched instruction
- in_instr  in  WORD_W  fetched instruction word
- out_valid  out  1  head entry is valid for decode
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  WORD_W  PC of head entry
- out_npc  out  WORD_W  out_pc + 4, for link/branch-target computation in decode
- out_instr  out  WORD_W  head instruction
- flush  in  1  discard all entries (PC redirect)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular buffer of DEPTH entries, each {pc, instr}.
  - wr_ptr, rd_ptr: $clog2(DEPTH) bits, wrap naturally (DEPTH-1 → 0).
  - count register: 0..DEPTH.
- Push = in_valid & in_ready: write entry at wr_ptr, wr_ptr += 1.
- Pop = out_valid & out_ready: rd_ptr += 1.
- count_next:
  - push & !pop: count + 1
  - pop & !push: count − 1
  - both, or neither: unchanged
- in_ready = (count != DEPTH) & !flush.
  - No full-queue pass-through: when full, in_ready = 0 even if out_ready = 1.
- out_valid = (count != 0) & !flush.
- out_pc, out_instr: storage at rd_ptr when out_valid = 1; forced to 0 otherwise. Instruction 0 is a nop (sll $0,$0,0), so an empty queue shows a bubble.
- out_npc = out_pc + 4, modulo 2^WORD_W. Wraps silently; 0 when out_valid = 0.
- Flush (highest priority):
  - Registered effect: wr_ptr = 0, rd_ptr = 0, count = 0.
  - In the flush cycle, in_ready = 0 and out_valid = 0, so no push or pop occurs.
  - Storage contents are don't-care afterwards.
- Reset (RST = 1 at a rising edge) has the same registered effect as flush.
  - Outputs after reset: count = 0, out_valid = 0, in_ready = 1, out_pc = out_instr = out_npc = 0.
  - Storage is not reset.
- RST overrides flush and all handshakes. Asserting it mid-stream discards all entries.

## Timing
- Entry pushed at edge N is visible at the head (out_valid = 1) in the cycle after N when the queue was empty. Minimum fetch-to-decode latency is 1 cycle. There is no same-cycle bypass.
- in_ready and out_valid are combinational from count and flush only. They do not depend on in_valid or out_ready, so no combinational loop is possible with fetch or decode.
- Sustained throughput is 1 entry/cycle with simultaneous push and pop at any occupancy 1..DEPTH−1.
- At full (count = DEPTH) with pop, the next cycle has count = DEPTH−1 and in_ready = 1. One bubble on the push side is accepted by design.
- At empty with push only, the next cycle has count = 1. A pop is impossible while empty.
- The first post-flush push is accepted the cycle after flush deasserts. Its entry appears at the head one cycle later.

## Test plan
- Reset, fill in order, drain: assert RST for 1 cycle; check count = 0, in_ready = 1, out_valid = 0, outputs 0. Push PCs 0x00, 0x04, 0x08, 0x0C with instrs 0x20080001.. and out_ready = 0. Check count = 4 and in_ready = 0. Raise out_ready and check four pops in order, each out_npc = out_pc + 4, then count = 0 and out_instr = 0.
- Streaming: in_valid = out_ready = 1 for 20 cycles with PC incrementing by 4. Check count stays 1 after the first cycle, with exactly 1 cycle of latency, no drops and no duplicates.
- Pointer wrap: perform 3·DEPTH + 1 push/pop with random out_ready stalls. A scoreboard matches every PC/instr in order, and count never exceeds 4.
- Flush with simultaneous push/pop: with count = 3, assert flush alongside in_valid = out_ready = 1. Check in_ready = out_valid = 0 in that cycle and count = 0 next. A subsequent push of PC 0x400 is the next head.
- Reset mid-operation: with count = 2, assert RST and flush together. Check count = 0 and out_valid = 0. The next push of PC 0x0 emerges after 1 cycle.
- Address wrap: push PC 0xFFFFFFFC and check out_npc = 0x00000000.

Source files
------------

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue : in-order {PC, instruction} queue between fetch and decode
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_pc,
  input  logic [WORD_W-1:0]        in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_pc,
  output logic [WORD_W-1:0]        out_npc,
  output logic [WORD_W-1:0]        out_instr,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int               PTR_W  = $clog2(DEPTH);
  localparam int               CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);

  logic [WORD_W-1:0] pc_mem    [DEPTH];
  logic [WORD_W-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push;
  logic             pop;

  // Handshake readiness depends only on occupancy and flush, never on the
  // partner's valid/ready, so no combinational loop can form.
  always_comb begin
    in_ready  = (count_q != FULL) && !flush;
    out_valid = (count_q != '0) && !flush;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; stale contents are masked by out_valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

  always_comb begin
    out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
    out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;
    out_npc   = out_valid ? (out_pc + WORD_W'(4)) : '0;
    count     = count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// ============================================================================
// tb_fetch_queue : scoreboard bench for fetch_queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH  = 4;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_pc;
  logic [WORD_W-1:0] in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_npc;
  logic [WORD_W-1:0] out_instr;
  logic              flush;
  logic [2:0]        count;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  logic [2*WORD_W-1:0] sb [$];

  fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .CLK       (clk),
    .RST       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_npc   (out_npc),
    .out_instr (out_instr),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: samples mid-cycle, checks head/occupancy, then
  // applies this cycle's handshake to the expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [2*WORD_W-1:0] head;
      logic                exp_v;
      logic [WORD_W-1:0]   exp_pc, exp_in, exp_np;
      exp_v  = (sb.size() != 0) && !flush;
      head   = (sb.size() != 0) ? sb[0] : '0;
      exp_pc = exp_v ? head[2*WORD_W-1:WORD_W] : '0;
      exp_in = exp_v ? head[WORD_W-1:0] : '0;
      exp_np = exp_v ? exp_pc + 32'd4 : '0;
      n_cmp++;
      if (count !== 3'(sb.size())) begin
        n_bad++; $display("FAIL mon_count: got %0d want %0d @%0t", count, sb.size(), $time);
      end
      n_cmp++;
      if (out_valid !== exp_v) begin
        n_bad++; $display("FAIL mon_out_valid: got %b want %b @%0t", out_valid, exp_v, $time);
      end
      n_cmp++;
      if (out_pc !== exp_pc || out_instr !== exp_in || out_npc !== exp_np) begin
        n_bad++;
        $display("FAIL mon_head: got pc=%h instr=%h npc=%h want pc=%h instr=%h npc=%h @%0t",
                 out_pc, out_instr, out_npc, exp_pc, exp_in, exp_np, $time);
      end
      if (rst || flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
        if (in_valid && in_ready) sb.push_back({in_pc, in_instr});
      end
    end
  end

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int lim = 0;
    idle_inputs();
    out_ready = 1'b1;
    while (count != 0 && lim < 40) begin
      next_cycle();
      lim++;
    end
    n_cmp++;
    if (count !== 3'd0) begin
      n_bad++; $display("FAIL drain_timeout: count=%0d want 0", count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: count=%0d in_ready=%b out_valid=%b want 0/1/0",
                        count, in_ready, out_valid);
    end
    n_cmp++;
    if (out_pc !== '0 || out_instr !== '0 || out_npc !== '0) begin
      n_bad++; $display("FAIL reset_data: pc=%h instr=%h npc=%h want 0", out_pc, out_instr, out_npc);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'(i * 4);
      in_instr = 32'h2008_0001 + 32'(i);
      next_cycle();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL fill_full: count=%0d in_ready=%b want 4/0", count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (out_pc !== 32'(i * 4) || out_npc !== 32'(i * 4 + 4)) begin
        n_bad++; $display("FAIL drain_order: pc=%h npc=%h want pc=%h", out_pc, out_npc, i * 4);
      end
      next_cycle();
    end
    out_ready = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || out_instr !== '0) begin
      n_bad++; $display("FAIL drain_empty: count=%0d instr=%h want 0/0", count, out_instr);
    end
  endtask

  task automatic test_streaming();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_pc    = 32'h100 + 32'(4 * i);
      in_instr = 32'hA000_0000 + 32'(i);
      if (i > 0) begin
        n_cmp++;
        if (count !== 3'd1 || out_pc !== 32'h100 + 32'(4 * (i - 1))) begin
          n_bad++; $display("FAIL stream: cyc %0d count=%0d pc=%h want 1/%h",
                            i, count, out_pc, 32'h100 + 32'(4 * (i - 1)));
        end
      end
      next_cycle();
    end
    drain();
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int lim    = 0;
    while (pushed < 3 * DEPTH + 1 && lim < 200) begin
      in_valid  = 1'b1;
      in_pc     = 32'h2000 + 32'(4 * pushed);
      in_instr  = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) pushed++;
      n_cmp++;
      if (count > 3'(DEPTH)) begin
        n_bad++; $display("FAIL wrap_bound: count=%0d exceeds %0d", count, DEPTH);
      end
      next_cycle();
      lim++;
    end
    n_cmp++;
    if (pushed != 3 * DEPTH + 1) begin
      n_bad++; $display("FAIL wrap_timeout: pushed=%0d want %0d", pushed, 3 * DEPTH + 1);
    end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h300 + 32'(4 * i);
      in_instr = 32'h1234_0000 + 32'(i);
      next_cycle();
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h999;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_cycle: in_ready=%b out_valid=%b want 0/0", in_ready, out_valid);
    end
    next_cycle();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_pc     = 32'h400;
    in_instr  = 32'h0000_0400;
    #1;
    n_cmp++;
    if (count !== 3'd0) begin
      n_bad++; $display("FAIL flush_count: count=%0d want 0", count);
    end
    next_cycle();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
      n_bad++; $display("FAIL flush_next_head: valid=%b pc=%h want 1/400", out_valid, out_pc);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h500 + 32'(4 * i);
      in_instr = 32'h5555_0000 + 32'(i);
      next_cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    flush    = 1'b1;
    next_cycle();
    rst   = 1'b0;
    flush = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid: count=%0d out_valid=%b want 0/0", count, out_valid);
    end
    in_valid = 1'b1;
    in_pc    = 32'h0;
    in_instr = 32'h0000_0011;
    next_cycle();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h11) begin
      n_bad++; $display("FAIL rst_mid_push: valid=%b pc=%h instr=%h want 1/0/11",
                        out_valid, out_pc, out_instr);
    end
    drain();
  endtask

  task automatic test_addr_wrap();
    in_valid = 1'b1;
    in_pc    = 32'hFFFF_FFFC;
    in_instr = 32'h0800_0000;
    next_cycle();
    in_valid = 1'b0;
    n_cmp++;
    if (out_pc !== 32'hFFFF_FFFC || out_npc !== 32'h0) begin
      n_bad++; $display("FAIL npc_wrap: pc=%h npc=%h want fffffffc/00000000", out_pc, out_npc);
    end
    drain();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_fill_drain();
    test_streaming();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_addr_wrap();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
